// File: rtl/inport_pkg.sv
// rtl/inport_pkg.sv - shared width helpers and mode constants for the input port bank
package inport_pkg;

    localparam int MODE_FIFO  = 0;
    localparam int MODE_LATCH = 1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int ptr_width(input int depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

    function automatic int cnt_width(input int depth);
        return clog2(depth) + 1;
    endfunction

    function automatic int sel_width(input int channels);
        return (channels > 1) ? clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/inport_chan.sv
// rtl/inport_chan.sv - one input channel: strobe synchroniser, edge detect, FIFO/latch storage, sticky flags
module inport_chan
    import inport_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int LATCH = MODE_FIFO
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        strobe_i,
    input  logic [WIDTH-1:0]            data_i,
    input  logic                        pop_i,
    input  logic                        flag_clr_i,
    output logic [WIDTH-1:0]            head_o,
    output logic [cnt_width(DEPTH)-1:0] count_o,
    output logic                        empty_o,
    output logic                        full_o,
    output logic                        overflow_o,
    output logic                        underflow_o
);
    localparam int PW = ptr_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [2:0]       sync_q;
    logic             push_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             is_empty, is_full, do_push, do_pop;

    // Push is registered so data_in is captured one edge after the detected rise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q   <= '0;
            push_q   <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            sync_q   <= {sync_q[1:0], strobe_i};
            push_q   <= sync_q[1] & ~sync_q[2];
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_comb begin
        is_empty = (cnt_q == '0);
        is_full  = (LATCH == MODE_LATCH) ? !is_empty : (cnt_q == CW'(DEPTH));
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (LATCH == MODE_LATCH) begin
            // Latch mode keeps a single word at slot 0 and never consumes it.
            do_pop  = 1'b0;
            do_push = push_q;
            if (do_push) begin
                cnt_d = CW'(1);
            end
        end else begin
            do_pop  = pop_i && !is_empty;
            do_push = push_q && (!is_full || do_pop);
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                cnt_d = cnt_q + 1'b1;
            end else if (do_pop && !do_push) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
        // A new event in the same cycle as flag_clr wins.
        ovf_d = (ovf_q & ~flag_clr_i) | (push_q & ~do_push);
        udf_d = (udf_q & ~flag_clr_i) | (pop_i & is_empty);
    end

    assign head_o      = is_empty ? '0 : mem_q[rd_ptr_q];
    assign count_o     = cnt_q;
    assign empty_o     = is_empty;
    assign full_o      = is_full;
    assign overflow_o  = ovf_q;
    assign underflow_o = udf_q;

endmodule

// File: rtl/inport_bank.sv
// rtl/inport_bank.sv - multi-channel strobe-loaded input port with per-channel FIFOs and status
module inport_bank
    import inport_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 4,
    parameter int CHANNELS = 2,
    parameter int LATCH    = MODE_FIFO
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic [CHANNELS-1:0]           strobe,
    input  logic [CHANNELS*WIDTH-1:0]     data_in,
    input  logic [sel_width(CHANNELS)-1:0] sel,
    input  logic                          InPortOut,
    input  logic                          flag_clr,
    output logic [WIDTH-1:0]              bus_out,
    output logic [cnt_width(DEPTH)-1:0]   count,
    output logic [CHANNELS-1:0]           empty,
    output logic [CHANNELS-1:0]           full,
    output logic [CHANNELS-1:0]           overflow,
    output logic [CHANNELS-1:0]           underflow
);
    localparam int CW = cnt_width(DEPTH);
    localparam int SW = sel_width(CHANNELS);

    logic [WIDTH-1:0] head [CHANNELS];
    logic [CW-1:0]    cnt  [CHANNELS];

    // Out-of-range sel matches no channel, so it reads zero and pops nothing.
    always_comb begin
        bus_out = '0;
        count   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (sel == SW'(c)) begin
                bus_out = head[c];
                count   = cnt[c];
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        inport_chan #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .LATCH (LATCH)
        ) u_chan (
            .clk_i       (clk),
            .rst_ni      (clr),
            .strobe_i    (strobe[c]),
            .data_i      (data_in[c*WIDTH +: WIDTH]),
            .pop_i       (InPortOut && (sel == SW'(c))),
            .flag_clr_i  (flag_clr && (sel == SW'(c))),
            .head_o      (head[c]),
            .count_o     (cnt[c]),
            .empty_o     (empty[c]),
            .full_o      (full[c]),
            .overflow_o  (overflow[c]),
            .underflow_o (underflow[c])
        );
    end

endmodule

// File: tb/tb_inport_bank.sv
// tb/tb_inport_bank.sv - self-checking bench for inport_bank in FIFO and LATCH builds
module tb_inport_bank;
    localparam int W  = 32;
    localparam int D  = 4;
    localparam int CH = 2;

    logic            clk = 1'b0;
    logic            clr;
    logic [CH-1:0]   strobe;
    logic [CH*W-1:0] data_in;
    logic            sel, pop, fclr;
    logic [W-1:0]    bus_out;
    logic [2:0]      count;
    logic [CH-1:0]   empty, full, ovf, udf;

    logic            l_strobe, l_sel, l_pop, l_fclr;
    logic [W-1:0]    l_data, l_bus;
    logic [2:0]      l_count;
    logic            l_empty, l_full, l_ovf, l_udf;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          op;
        int          ch;
        logic [31:0] d;
        int          cnt;
        logic [31:0] bus;
        logic        emp;
        logic        ful;
        logic        ovf;
        logic        udf;
    } vec_t;

    vec_t        tbl [16];
    logic [31:0] mq [CH][$];
    bit          m_ovf [CH];
    bit          m_udf [CH];
    logic [31:0] rd [CH];

    inport_bank #(.WIDTH(W), .DEPTH(D), .CHANNELS(CH), .LATCH(0)) dut (
        .clk(clk), .clr(clr), .strobe(strobe), .data_in(data_in), .sel(sel),
        .InPortOut(pop), .flag_clr(fclr), .bus_out(bus_out), .count(count),
        .empty(empty), .full(full), .overflow(ovf), .underflow(udf)
    );

    inport_bank #(.WIDTH(W), .DEPTH(D), .CHANNELS(1), .LATCH(1)) dut_l (
        .clk(clk), .clr(clr), .strobe(l_strobe), .data_in(l_data), .sel(l_sel),
        .InPortOut(l_pop), .flag_clr(l_fclr), .bus_out(l_bus), .count(l_count),
        .empty(l_empty), .full(l_full), .overflow(l_ovf), .underflow(l_udf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input logic [31:0] d, input bit with_pop);
        data_in[c*W +: W] = d;
        strobe[c] = 1'b1;
        tick();
        strobe[c] = 1'b0;
        tick();
        tick();
        if (with_pop) pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    task automatic do_pop(input int s);
        sel = s[0];
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    task automatic do_fclr(input int s);
        sel = s[0];
        fclr = 1'b1;
        tick();
        fclr = 1'b0;
    endtask

    task automatic lpush(input logic [31:0] d);
        l_data = d;
        l_strobe = 1'b1;
        tick();
        l_strobe = 1'b0;
        tick();
        tick();
        tick();
    endtask

    initial begin
        clr = 1'b0; strobe = '0; data_in = '0; sel = 1'b0; pop = 1'b0; fclr = 1'b0;
        l_strobe = 1'b0; l_data = '0; l_sel = 1'b0; l_pop = 1'b0; l_fclr = 1'b0;
        tick();
        tick();
        chk("rst empty", empty, 2'b11);
        chk("rst full", full, 0);
        chk("rst count", count, 0);
        chk("rst bus", bus_out, 0);
        chk("rst ovf", ovf, 0);
        chk("rst udf", udf, 0);
        clr = 1'b1;
        tick();

        // First push latency: sampled at edge n, visible after edge n+3.
        data_in[0 +: W] = 32'd2;
        strobe[0] = 1'b1;
        tick();
        chk("lat n", empty[0], 1);
        strobe[0] = 1'b0;
        tick();
        chk("lat n+1", empty[0], 1);
        tick();
        chk("lat n+2", empty[0], 1);
        tick();
        chk("lat n+3", empty[0], 0);
        sel = 1'b0;
        #1;
        chk("first bus", bus_out, 2);
        chk("first count", count, 1);
        do_pop(0);
        chk("first pop count", count, 0);
        chk("first pop empty", empty[0], 1);
        chk("first pop bus", bus_out, 0);

        tbl[0]  = '{0, 0, 5, 1, 5, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 6, 2, 5, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 7, 3, 5, 0, 0, 0, 0};
        tbl[3]  = '{0, 0, 8, 4, 5, 0, 1, 0, 0};
        tbl[4]  = '{0, 0, 9, 4, 5, 0, 1, 1, 0};
        tbl[5]  = '{1, 0, 0, 3, 6, 0, 0, 1, 0};
        tbl[6]  = '{1, 0, 0, 2, 7, 0, 0, 1, 0};
        tbl[7]  = '{1, 0, 0, 1, 8, 0, 0, 1, 0};
        tbl[8]  = '{1, 0, 0, 0, 0, 1, 0, 1, 0};
        tbl[9]  = '{2, 0, 0, 0, 0, 1, 0, 0, 0};
        tbl[10] = '{1, 0, 0, 0, 0, 1, 0, 0, 1};
        tbl[11] = '{2, 0, 0, 0, 0, 1, 0, 0, 0};
        tbl[12] = '{0, 1, 1, 1, 1, 0, 0, 0, 0};
        tbl[13] = '{0, 1, 2, 2, 1, 0, 0, 0, 0};
        tbl[14] = '{0, 1, 3, 3, 1, 0, 0, 0, 0};
        tbl[15] = '{0, 1, 4, 4, 1, 0, 1, 0, 0};
        for (int i = 0; i < 16; i++) begin
            case (tbl[i].op)
                0:       push(tbl[i].ch, tbl[i].d, 1'b0);
                1:       do_pop(tbl[i].ch);
                default: do_fclr(tbl[i].ch);
            endcase
            sel = tbl[i].ch[0];
            #1;
            chk($sformatf("vec%0d count", i), count, tbl[i].cnt);
            chk($sformatf("vec%0d bus", i), bus_out, tbl[i].bus);
            chk($sformatf("vec%0d empty", i), empty[tbl[i].ch], tbl[i].emp);
            chk($sformatf("vec%0d full", i), full[tbl[i].ch], tbl[i].ful);
            chk($sformatf("vec%0d ovf", i), ovf[tbl[i].ch], tbl[i].ovf);
            chk($sformatf("vec%0d udf", i), udf[tbl[i].ch], tbl[i].udf);
        end

        // Push and pop on the same edge while ch1 is full.
        sel = 1'b1;
        push(1, 32'hA5, 1'b1);
        chk("pp count", count, 4);
        chk("pp full", full[1], 1);
        chk("pp ovf", ovf[1], 0);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] exp_w;
            exp_w = (k == 3) ? 32'hA5 : 32'(k + 2);
            chk($sformatf("drain%0d", k), bus_out, exp_w);
            do_pop(1);
        end
        chk("drain empty", empty[1], 1);
        do_pop(1);
        chk("udf1 flag", udf[1], 1);
        chk("udf1 bus", bus_out, 0);
        chk("udf1 count", count, 0);

        // Asynchronous reset with three words buffered.
        push(0, 32'h11, 1'b0);
        push(0, 32'h12, 1'b0);
        push(0, 32'h13, 1'b0);
        sel = 1'b0;
        #3;
        clr = 1'b0;
        #1;
        chk("arst count", count, 0);
        chk("arst empty", empty, 2'b11);
        chk("arst udf", udf, 0);
        chk("arst bus", bus_out, 0);
        tick();
        clr = 1'b1;
        tick();

        for (int v = 1; v <= 10; v++) begin
            push(0, 32'(v), 1'b0);
            sel = 1'b0;
            #1;
            chk($sformatf("wrap%0d bus", v), bus_out, v);
            do_pop(0);
            chk($sformatf("wrap%0d empty", v), empty[0], 1);
        end

        for (int c = 0; c < CH; c++) begin
            mq[c].delete();
            m_ovf[c] = 0;
            m_udf[c] = 0;
        end
        do_fclr(0);
        do_fclr(1);
        for (int it = 0; it < 80; it++) begin
            logic [CH-1:0] pm;
            bit p, f;
            int s;
            pm = CH'($urandom_range(0, 3));
            p = (it < 40) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 7) == 0);
            s = $urandom_range(0, 1);
            for (int c = 0; c < CH; c++) begin
                rd[c] = $urandom;
                if (pm[c]) begin
                    data_in[c*W +: W] = rd[c];
                    strobe[c] = 1'b1;
                end
            end
            tick();
            strobe = '0;
            tick();
            tick();
            sel = s[0]; pop = p; fclr = f;
            tick();
            pop = 1'b0; fclr = 1'b0;
            for (int c = 0; c < CH; c++) begin
                if (f && s == c) begin
                    m_ovf[c] = 0;
                    m_udf[c] = 0;
                end
                if (p && s == c) begin
                    if (mq[c].size() == 0) m_udf[c] = 1;
                    else void'(mq[c].pop_front());
                end
                if (pm[c]) begin
                    if (mq[c].size() == D) m_ovf[c] = 1;
                    else mq[c].push_back(rd[c]);
                end
            end
            for (int c = 0; c < CH; c++) begin
                sel = c[0];
                #1;
                chk($sformatf("rnd%0d.%0d count", it, c), count, mq[c].size());
                chk($sformatf("rnd%0d.%0d bus", it, c), bus_out,
                    (mq[c].size() > 0) ? mq[c][0] : 32'd0);
                chk($sformatf("rnd%0d.%0d empty", it, c), empty[c], mq[c].size() == 0);
                chk($sformatf("rnd%0d.%0d full", it, c), full[c], mq[c].size() == D);
                chk($sformatf("rnd%0d.%0d ovf", it, c), ovf[c], m_ovf[c]);
                chk($sformatf("rnd%0d.%0d udf", it, c), udf[c], m_udf[c]);
            end
        end

        // LATCH build, single channel: sel=1 is out of range.
        l_sel = 1'b1;
        l_pop = 1'b1;
        tick();
        l_pop = 1'b0;
        chk("l oor udf", l_udf, 0);
        chk("l oor bus", l_bus, 0);
        l_sel = 1'b0;
        l_pop = 1'b1;
        tick();
        l_pop = 1'b0;
        chk("l early udf", l_udf, 1);
        l_fclr = 1'b1;
        tick();
        l_fclr = 1'b0;
        chk("l fclr udf", l_udf, 0);
        lpush(32'd11);
        chk("l bus 11", l_bus, 11);
        lpush(32'd22);
        chk("l bus 22", l_bus, 22);
        chk("l ovf", l_ovf, 0);
        chk("l full", l_full, 1);
        for (int k = 0; k < 3; k++) begin
            l_pop = 1'b1;
            tick();
            l_pop = 1'b0;
            chk($sformatf("l pop%0d bus", k), l_bus, 22);
            chk($sformatf("l pop%0d empty", k), l_empty, 0);
            chk($sformatf("l pop%0d count", k), l_count, 1);
        end
        chk("l final ovf", l_ovf, 0);
        l_sel = 1'b1;
        #1;
        chk("l oor bus2", l_bus, 0);
        chk("l oor count", l_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
